// File: rtl/rr_arbiter_2_x_1.sv
// rtl/rr_arbiter_2_x_1.sv - two-source round-robin arbiter with one-entry registered output stage
module rr_arbiter_2_x_1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             select,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_src,
    input  logic             m_ready,
    output logic [7:0]       cnt_a,
    output logic [7:0]       cnt_b
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_last_a;
    logic             r_select;
    logic             r_m_src;
    logic [WIDTH-1:0] r_m_data;
    logic [7:0]       r_cnt_a;
    logic [7:0]       r_cnt_b;

    logic w_load;
    logic w_grant_a;
    logic w_grant_b;
    logic w_grant;

    // In FULL, m_valid is 1, so the drain term reduces to m_ready; reset masks all grants.
    assign w_load    = !rst && ((r_state == EMPTY) || m_ready);
    assign w_grant_a = w_load && a_valid && (!b_valid || !r_last_a);
    assign w_grant_b = w_load && b_valid && (!a_valid ||  r_last_a);
    assign w_grant   = w_grant_a || w_grant_b;

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;
    assign select  = w_grant ? w_grant_a : r_select;
    assign m_valid = (r_state == FULL);
    assign m_data  = r_m_data;
    assign m_src   = r_m_src;
    assign cnt_a   = r_cnt_a;
    assign cnt_b   = r_cnt_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_last_a <= 1'b0;
            r_select <= 1'b0;
            r_m_src  <= 1'b0;
            r_m_data <= '0;
            r_cnt_a  <= 8'd0;
            r_cnt_b  <= 8'd0;
        end else if (w_grant) begin
            r_state  <= FULL;
            r_last_a <= w_grant_a;
            r_select <= w_grant_a;
            r_m_src  <= w_grant_a;
            r_m_data <= w_grant_a ? a_data : b_data;
            if (w_grant_a) r_cnt_a <= r_cnt_a + 8'd1;
            else           r_cnt_b <= r_cnt_b + 8'd1;
        end else if (r_state == FULL && m_ready) begin
            r_state <= EMPTY;
        end
    end

endmodule
